// File: rtl/mem_access_unit_pkg.sv
// Shared op codes, byte-enable constants and FSM encoding for the memory access unit.
package mem_access_unit_pkg;

    localparam logic [7:0] MEM_NONE = 8'h00;
    localparam logic [7:0] MEM_LB   = 8'h01;
    localparam logic [7:0] MEM_LBU  = 8'h02;
    localparam logic [7:0] MEM_LH   = 8'h03;
    localparam logic [7:0] MEM_LHU  = 8'h04;
    localparam logic [7:0] MEM_LW   = 8'h05;
    localparam logic [7:0] MEM_SB   = 8'h06;
    localparam logic [7:0] MEM_SH   = 8'h07;
    localparam logic [7:0] MEM_SW   = 8'h08;

    localparam int BE_W = 4;
    localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_mem_op(input logic [7:0] op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) || (op == MEM_LHU) ||
               (op == MEM_LW) || (op == MEM_SB)  || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
        if ((op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH)) return a[0];
        if ((op == MEM_LW) || (op == MEM_SW)) return (a != 2'b00);
        return 1'b0;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load lane extraction: picks the byte/half selected by addr[1:0] and sign/zero extends it.
module load_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [7:0]        op,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = '0;
        case (op)
            MEM_LB:  result = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            MEM_LBU: result = {{(DATA_W-8){1'b0}}, byte_sel};
            MEM_LH:  result = {{(DATA_W-16){half_sel[15]}}, half_sel};
            MEM_LHU: result = {{(DATA_W-16){1'b0}}, half_sel};
            MEM_LW:  result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: stalls EX while a single bus transaction (req until ack or timeout) completes.
// Bus handshake: ram_req_o stays high with stable address/data/enables until ram_ack_i is sampled high on a clk edge.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [4:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [7:0]        mem_op,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              we_o,
    output logic [4:0]        waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic [BE_W-1:0]   ram_be_o,
    input  logic              ram_ack_i,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              stall_o,
    output logic              addr_err_o,
    output logic              bus_err_o,
    output state_t            state_dbg
);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] load_result;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] store_data;
    logic              op_valid, misaligned, go;

    assign op_valid   = is_mem_op(mem_op);
    assign misaligned = op_valid && is_misaligned(mem_op, mem_addr_i[1:0]);
    assign go         = op_valid && !misaligned;
    assign state_dbg  = state_q;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .op     (mem_op),
        .addr   (mem_addr_i[1:0]),
        .word   (rdata_q),
        .result (load_result)
    );

    always_comb begin
        be         = '0;
        store_data = '0;
        case (mem_op)
            MEM_LB, MEM_LBU: be = BE_BYTE << mem_addr_i[1:0];
            MEM_LH, MEM_LHU: be = BE_HALF << mem_addr_i[1:0];
            MEM_LW:          be = BE_WORD;
            MEM_SB: begin
                be         = BE_BYTE << mem_addr_i[1:0];
                store_data = {4{mem_data_i[7:0]}};
            end
            MEM_SH: begin
                be         = BE_HALF << mem_addr_i[1:0];
                store_data = {2{mem_data_i[15:0]}};
            end
            MEM_SW: begin
                be         = BE_WORD;
                store_data = mem_data_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        we_o       = 1'b0;
        waddr_o    = '0;
        wdata_o    = '0;
        ram_req_o  = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        ram_be_o   = '0;
        stall_o    = 1'b0;
        addr_err_o = 1'b0;
        bus_err_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                err_d = 1'b0;
                if (go) begin
                    stall_o = 1'b1;
                    state_d = ST_REQ;
                end else if (misaligned) begin
                    addr_err_o = 1'b1;
                end else begin
                    we_o    = we_i;
                    waddr_o = waddr_i;
                    wdata_o = wdata_i;
                end
            end
            ST_REQ: begin
                stall_o   = 1'b1;
                ram_req_o = 1'b1;
                if (ram_ack_i) begin
                    rdata_d = ram_data_i;
                    state_d = ST_DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // Last allowed request cycle without ack: abandon the access.
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                waddr_o   = waddr_i;
                bus_err_o = err_q;
                if (!err_q && !is_store(mem_op)) begin
                    we_o    = we_i;
                    wdata_o = load_result;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ram_req_o) begin
            ram_we_o   = is_store(mem_op);
            ram_addr_o = {mem_addr_i[ADDR_W-1:2], 2'b00};
            ram_data_o = store_data;
            ram_be_o   = be;
        end

        if (rst) begin
            we_o       = 1'b0;
            waddr_o    = '0;
            wdata_o    = '0;
            ram_req_o  = 1'b0;
            ram_we_o   = 1'b0;
            ram_addr_o = '0;
            ram_data_o = '0;
            ram_be_o   = '0;
            stall_o    = 1'b0;
            addr_err_o = 1'b0;
            bus_err_o  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table-driven single-cycle and transaction vectors plus timeout/reset sequences.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [7:0]  mem_op;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [3:0]  ram_be_o;
    logic        ram_ack_i;
    logic [31:0] ram_data_i;
    logic        stall_o;
    logic        addr_err_o;
    logic        bus_err_o;
    state_t      state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .mem_op     (mem_op),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i),
        .we_o       (we_o),
        .waddr_o    (waddr_o),
        .wdata_o    (wdata_o),
        .ram_req_o  (ram_req_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_o (ram_data_o),
        .ram_be_o   (ram_be_o),
        .ram_ack_i  (ram_ack_i),
        .ram_data_i (ram_data_i),
        .stall_o    (stall_o),
        .addr_err_o (addr_err_o),
        .bus_err_o  (bus_err_o),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // checkers
    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // vector tables
    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        exp_we;
        logic        exp_err;
        string       name;
    } idle_vec_t;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rword;
        logic [31:0] exp_ram_addr;
        logic [3:0]  exp_be;
        logic        exp_ram_we;
        logic [31:0] exp_ram_data;
        logic        exp_we;
        logic [31:0] exp_wdata;
        string       name;
    } txn_vec_t;

    idle_vec_t idle_vecs[7];
    txn_vec_t  txn_vecs[10];

    // driver: one load/store with ack in the first request cycle
    task automatic run_txn(input txn_vec_t t);
        int stall_cnt;
        stall_cnt = 0;
        @(negedge clk);
        mem_op     = t.op;
        mem_addr_i = t.addr;
        mem_data_i = t.sdata;
        we_i       = 1'b1;
        waddr_i    = 5'd9;
        wdata_i    = 32'h0BAD0BAD;
        exp_q.push_back(t.exp_wdata);
        #1;
        chk_bit({t.name, "_idle_req"}, ram_req_o, 1'b0);
        if (stall_o) stall_cnt++;
        @(negedge clk);
        ram_ack_i  = 1'b1;
        ram_data_i = t.rword;
        #1;
        if (stall_o) stall_cnt++;
        chk_bit({t.name, "_req"}, ram_req_o, 1'b1);
        chk_word({t.name, "_ram_addr"}, ram_addr_o, t.exp_ram_addr);
        chk_word({t.name, "_be"}, 32'(ram_be_o), 32'(t.exp_be));
        chk_bit({t.name, "_ram_we"}, ram_we_o, t.exp_ram_we);
        if (t.exp_ram_we) chk_word({t.name, "_ram_data"}, ram_data_o, t.exp_ram_data);
        @(negedge clk);
        ram_ack_i  = 1'b0;
        ram_data_i = 32'hDEADDEAD;
        #1;
        if (stall_o) stall_cnt++;
        chk_int({t.name, "_stall_cycles"}, stall_cnt, 2);
        chk_bit({t.name, "_we"}, we_o, t.exp_we);
        chk_word({t.name, "_wdata"}, wdata_o, exp_q.pop_front());
        chk_bit({t.name, "_bus_err"}, bus_err_o, 1'b0);
        if (t.exp_we) chk_word({t.name, "_waddr"}, 32'(waddr_o), 32'd9);
        @(negedge clk);
        mem_op = MEM_NONE;
        #1;
        chk_word({t.name, "_back_idle"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    int   req_cnt;
    logic req_stable;

    initial begin
        idle_vecs[0] = '{MEM_NONE, 32'h0,    1'b1, 5'd7,  32'h12345678, 1'b1, 1'b0, "none_a"};
        idle_vecs[1] = '{MEM_NONE, 32'h3,    1'b0, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, "none_b"};
        idle_vecs[2] = '{MEM_LW,   32'h3002, 1'b1, 5'd3,  32'h0,        1'b0, 1'b1, "lw_mis"};
        idle_vecs[3] = '{MEM_LH,   32'h3001, 1'b1, 5'd3,  32'h0,        1'b0, 1'b1, "lh_mis"};
        idle_vecs[4] = '{MEM_LHU,  32'h3003, 1'b1, 5'd3,  32'h0,        1'b0, 1'b1, "lhu_mis"};
        idle_vecs[5] = '{MEM_SW,   32'h3003, 1'b1, 5'd3,  32'h0,        1'b0, 1'b1, "sw_mis"};
        idle_vecs[6] = '{MEM_SH,   32'h3005, 1'b1, 5'd3,  32'h0,        1'b0, 1'b1, "sh_mis"};

        txn_vecs[0] = '{MEM_LB,  32'h1003, 32'h0, 32'h80AA5511, 32'h1000, 4'b1000, 1'b0, 32'h0, 1'b1, 32'hFFFFFF80, "lb3"};
        txn_vecs[1] = '{MEM_LBU, 32'h1003, 32'h0, 32'h80AA5511, 32'h1000, 4'b1000, 1'b0, 32'h0, 1'b1, 32'h00000080, "lbu3"};
        txn_vecs[2] = '{MEM_LB,  32'h1001, 32'h0, 32'h80AA5511, 32'h1000, 4'b0010, 1'b0, 32'h0, 1'b1, 32'h00000055, "lb1"};
        txn_vecs[3] = '{MEM_LH,  32'h1002, 32'h0, 32'h80AA5511, 32'h1000, 4'b1100, 1'b0, 32'h0, 1'b1, 32'hFFFF80AA, "lh2"};
        txn_vecs[4] = '{MEM_LHU, 32'h1002, 32'h0, 32'h80AA5511, 32'h1000, 4'b1100, 1'b0, 32'h0, 1'b1, 32'h000080AA, "lhu2"};
        txn_vecs[5] = '{MEM_LH,  32'h1000, 32'h0, 32'h80AA5511, 32'h1000, 4'b0011, 1'b0, 32'h0, 1'b1, 32'h00005511, "lh0"};
        txn_vecs[6] = '{MEM_LW,  32'h1004, 32'h0, 32'h80AA5511, 32'h1004, 4'b1111, 1'b0, 32'h0, 1'b1, 32'h80AA5511, "lw"};
        txn_vecs[7] = '{MEM_SH,  32'h2002, 32'h0000BEEF, 32'h0, 32'h2000, 4'b1100, 1'b1, 32'hBEEFBEEF, 1'b0, 32'h0, "sh2"};
        txn_vecs[8] = '{MEM_SB,  32'h2001, 32'h123456A5, 32'h0, 32'h2000, 4'b0010, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0, "sb1"};
        txn_vecs[9] = '{MEM_SW,  32'h2004, 32'hDEADBEEF, 32'h0, 32'h2004, 4'b1111, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, "sw"};

        // reset with live inputs: every output must read 0
        rst        = 1'b1;
        we_i       = 1'b1;
        waddr_i    = 5'd7;
        wdata_i    = 32'h12345678;
        mem_op     = MEM_NONE;
        mem_addr_i = '0;
        mem_data_i = '0;
        ram_ack_i  = 1'b0;
        ram_data_i = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_bit("rst_we", we_o, 1'b0);
        chk_word("rst_wdata", wdata_o, 32'h0);
        chk_bit("rst_stall", stall_o, 1'b0);
        chk_bit("rst_req", ram_req_o, 1'b0);
        chk_word("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;

        // single-cycle vectors evaluated in IDLE
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            mem_op     = idle_vecs[i].op;
            mem_addr_i = idle_vecs[i].addr;
            we_i       = idle_vecs[i].we;
            waddr_i    = idle_vecs[i].waddr;
            wdata_i    = idle_vecs[i].wdata;
            #1;
            chk_bit({idle_vecs[i].name, "_we"}, we_o, idle_vecs[i].exp_we);
            chk_bit({idle_vecs[i].name, "_stall"}, stall_o, 1'b0);
            chk_bit({idle_vecs[i].name, "_req"}, ram_req_o, 1'b0);
            chk_bit({idle_vecs[i].name, "_addr_err"}, addr_err_o, idle_vecs[i].exp_err);
            if (!idle_vecs[i].exp_err) begin
                chk_word({idle_vecs[i].name, "_waddr"}, 32'(waddr_o), 32'(idle_vecs[i].waddr));
                chk_word({idle_vecs[i].name, "_wdata"}, wdata_o, idle_vecs[i].wdata);
            end
        end
        @(negedge clk);
        #1;
        chk_bit("mis_hold_req", ram_req_o, 1'b0);
        chk_word("mis_hold_state", 32'(state_dbg), 32'(ST_IDLE));
        mem_op = MEM_NONE;

        for (int i = 0; i < 10; i++) run_txn(txn_vecs[i]);

        // timeout: LHU with ack withheld
        @(negedge clk);
        mem_op     = MEM_LHU;
        mem_addr_i = 32'h4002;
        we_i       = 1'b1;
        waddr_i    = 5'd4;
        #1;
        chk_bit("to_idle_stall", stall_o, 1'b1);
        req_cnt    = 0;
        req_stable = 1'b1;
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            @(negedge clk);
            #1;
            if (!ram_req_o) break;
            req_cnt++;
            if (ram_addr_o !== 32'h4000 || ram_be_o !== 4'b1100 || bus_err_o || !stall_o)
                req_stable = 1'b0;
        end
        chk_int("to_req_cycles", req_cnt, TIMEOUT);
        chk_bit("to_req_stable", req_stable, 1'b1);
        chk_bit("to_bus_err", bus_err_o, 1'b1);
        chk_bit("to_we", we_o, 1'b0);
        chk_bit("to_stall", stall_o, 1'b0);
        @(negedge clk);
        mem_op = MEM_NONE;
        #1;
        chk_bit("to_bus_err_clear", bus_err_o, 1'b0);
        chk_word("to_state", 32'(state_dbg), 32'(ST_IDLE));

        // reset in the second REQ cycle of a load
        @(negedge clk);
        mem_op     = MEM_LW;
        mem_addr_i = 32'h5000;
        we_i       = 1'b1;
        waddr_i    = 5'd12;
        @(negedge clk);
        #1;
        chk_bit("rm_req1", ram_req_o, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_bit("rm_req_gated", ram_req_o, 1'b0);
        chk_bit("rm_stall_gated", stall_o, 1'b0);
        @(negedge clk);
        #1;
        chk_word("rm_state", 32'(state_dbg), 32'(ST_IDLE));
        chk_bit("rm_req_after", ram_req_o, 1'b0);
        chk_bit("rm_stall_after", stall_o, 1'b0);
        rst = 1'b0;
        #1;
        chk_bit("rm_restart_stall", stall_o, 1'b1);
        chk_bit("rm_restart_req", ram_req_o, 1'b0);
        @(negedge clk);
        ram_ack_i  = 1'b1;
        ram_data_i = 32'h11223344;
        #1;
        chk_bit("rm_req2", ram_req_o, 1'b1);
        chk_word("rm_addr", ram_addr_o, 32'h5000);
        @(negedge clk);
        ram_ack_i = 1'b0;
        #1;
        chk_bit("rm_we", we_o, 1'b1);
        chk_word("rm_wdata", wdata_o, 32'h11223344);
        chk_bit("rm_stall_done", stall_o, 1'b0);

        // stray ack while idle
        @(negedge clk);
        mem_op     = MEM_NONE;
        ram_ack_i  = 1'b1;
        ram_data_i = 32'hFFFFFFFF;
        #1;
        chk_bit("ack_idle_bus_err", bus_err_o, 1'b0);
        chk_bit("ack_idle_req", ram_req_o, 1'b0);
        @(negedge clk);
        #1;
        chk_word("ack_idle_state", 32'(state_dbg), 32'(ST_IDLE));
        chk_bit("ack_idle_stall", stall_o, 1'b0);
        ram_ack_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data path width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum number of cycles to wait for ram_ack_i, range 1..255.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports we_i / waddr_i / wdata_i, input, 1/5/DATA_W: register writeback request from EX.
REQ-007 SHALL have port mem_op, input, 8: memory operation code from the package.
REQ-008 SHALL have ports mem_addr_i / mem_data_i, input, ADDR_W/DATA_W: effective address and store data.
REQ-009 SHALL have ports we_o / waddr_o / wdata_o, output, 1/5/DATA_W: writeback to WB.
REQ-010 SHALL have ports ram_req_o / ram_we_o, output, 1 each: bus request, and write (1) / read (0).
REQ-011 SHALL have ports ram_addr_o / ram_data_o / ram_be_o, output, ADDR_W/DATA_W/4: word-aligned address, write data, active-high byte enables.
REQ-012 SHALL have ports ram_ack_i / ram_data_i, input, 1/DATA_W: bus completion and read data.
REQ-013 SHALL have ports stall_o / addr_err_o / bus_err_o, output, 1 each: pipeline hold, misalignment flag, timeout flag.

Function
REQ-014 SHALL, for mem_op = MEM_NONE, pass through combinationally with zero latency: we_o=we_i, waddr_o=waddr_i, wdata_o=wdata_i, stall_o=0, ram_req_o=0.
REQ-015 SHALL support LB, LBU, LH, LHU, LW, SB, SH and SW in little-endian order, with the byte lane selected by addr[1:0].
REQ-016 SHALL treat an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]≠0, as misaligned: no bus request, addr_err_o=1, we_o=0 and stall_o=0 for that cycle.
REQ-017 SHALL implement an FSM with states IDLE, REQ and DONE.
REQ-018 SHALL, in IDLE on a valid memory op, assert stall_o combinationally and move to REQ at the next edge.
REQ-019 SHALL, in REQ, hold ram_req_o=1 and keep ram_addr_o (= {addr[ADDR_W-1:2],2'b00}), ram_be_o, ram_we_o and ram_data_o stable until ram_ack_i.
REQ-020 SHALL, in REQ with ram_ack_i sampled high, latch ram_data_i and move to DONE.
REQ-021 SHALL drive byte enables as: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-022 SHALL replicate store data across all lanes (byte ×4, half ×2).
REQ-023 SHALL, in DONE, drive stall_o=0 for exactly one cycle and return to IDLE next.
REQ-024 SHALL, in DONE for a load, drive we_o=we_i and wdata_o = the extracted lane, sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-025 SHALL, in DONE for a store, drive we_o=0.
REQ-026 SHALL count REQ cycles; if the count reaches TIMEOUT without an ack: drop ram_req_o, go to DONE, pulse bus_err_o for 1 cycle, force we_o=0.
REQ-027 SHALL give a minimum load/store latency of 2 stalled cycles (IDLE detect plus REQ with same-cycle ack) followed by the DONE cycle.
REQ-028 SHALL ignore an ack in IDLE or DONE, and shall not raise an error for it.
REQ-029 SHALL require upstream to hold mem_op, mem_addr_i, mem_data_i, we_i and waddr_i stable while stall_o=1.
REQ-030 SHALL keep ram_* outputs at 0 whenever ram_req_o=0.

Reset
REQ-031 SHALL, on rst high at a clock edge, enter IDLE, clear the timeout counter and the latched data, and drop ram_req_o at that edge even if mid-transaction.
REQ-032 SHALL hold all outputs at 0 while rst is high, including we_o, stall_o and both error flags.

Structure
REQ-033 SHALL take the MEM_* op codes, the byte-enable widths and the FSM state encoding from the shared include/package; no local literals.
REQ-034 SHALL place load extraction and extension in one combinational sub-module, load_align (inputs: op, addr[1:0], word; output: DATA_W result).

Verification
REQ-035 SHALL check: LB addr 0x1003, ram word 0x80AA5511, ack in the first REQ cycle -> wdata_o=0xFFFFFF80 in DONE, stall_o high for 2 cycles.
REQ-036 SHALL check: SH addr 0x2002, data 0x0000BEEF -> ram_be_o=4'b1100, ram_data_o=0xBEEFBEEF, ram_we_o=1, we_o=0 in DONE.
REQ-037 SHALL check: LW addr 0x3002 -> addr_err_o=1, ram_req_o never asserted, stall_o=0.
REQ-038 SHALL check: LHU addr 0x4002, ack withheld -> ram_req_o held for TIMEOUT cycles, then bus_err_o pulses once and we_o=0.
REQ-039 SHALL check: rst asserted in the second REQ cycle of a load -> ram_req_o=0 and stall_o=0 after that edge, and the next op starts from IDLE.
REQ-040 SHALL check: MEM_NONE with we_i=1, waddr_i=7, wdata_i=0x12345678 -> identical outputs in the same cycle, stall_o=0.
